// File: rtl/ex_operand_ctrl.sv
// ex_operand_ctrl: EX-stage operand-select sequencer for the 3-stage pipeline (ID, EX, WB).
// It tracks the destination register of the instructions in EX and WB. Each ID instruction
// gets its operand selects registered, so they appear at the same edge it enters EX.
// A forward to wb_val is picked when the instruction now in EX writes a source register
// of the ID instruction.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   id_valid, id_rs1/rs2/rd    ID instruction presence and register indices
//   id_regwen                  ID instruction writes rd
//   id_uses_rs1/rs2            operand A/B reads rs1/rs2
//   id_a_is_pc, id_b_is_imm    operand A is pc / operand B is imm
//   stall                      hold every stage
//   flush                      kill the ID instruction; remembered if it arrives while stalled
//   ex_asel, ex_bsel           operand selects for EX (0=reg, 1=pc/imm, 2=wb_val)
//   ex_valid                   EX holds a real instruction
//   wb_valid, wb_rd, wb_regwen WB stage state (wb_regwen already gated by wb_valid)
//
// Optional feature (macro EX_FWD_STATS_EN): adds the fwd_cnt and bubble_cnt outputs.
// fwd_cnt counts advancing edges that select a forward. bubble_cnt counts advancing edges
// that kill a valid ID instruction.

module ex_operand_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter bit          FWD_X0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwen,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_a_is_pc,
  input  logic              id_b_is_imm,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        ex_asel,
  output logic [1:0]        ex_bsel,
  output logic              ex_valid,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_regwen
`ifdef EX_FWD_STATS_EN
  ,
  output logic [31:0]       fwd_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_ALT = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // Pipeline state
  logic [1:0]        r_ex_asel;
  logic [1:0]        r_ex_bsel;
  logic              r_ex_valid;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_regwen;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_regwen;
  logic              r_pending_flush;

  // Next-state terms
  logic       w_adv;
  logic       w_kill;
  logic       w_id_live;
  logic       w_hit_a;
  logic       w_hit_b;
  logic [1:0] w_asel_nxt;
  logic [1:0] w_bsel_nxt;
  logic       w_fwd_sel;
  logic       w_bubble;

  // Forward detection against the current EX instruction plus select priority
  always_comb begin
    w_adv      = !stall;
    w_kill     = flush | r_pending_flush;
    w_id_live  = id_valid & !w_kill;
    // r_ex_regwen is only ever set for live instructions, so a bubble never hits
    w_hit_a    = id_uses_rs1 & r_ex_valid & r_ex_regwen & (r_ex_rd == id_rs1)
               & ((id_rs1 != '0) | FWD_X0);
    w_hit_b    = id_uses_rs2 & r_ex_valid & r_ex_regwen & (r_ex_rd == id_rs2)
               & ((id_rs2 != '0) | FWD_X0);
    w_asel_nxt = SEL_REG;
    w_bsel_nxt = SEL_REG;
    if (w_id_live) begin
      if (id_a_is_pc)       w_asel_nxt = SEL_ALT;
      else if (w_hit_a)     w_asel_nxt = SEL_WB;
      if (id_b_is_imm)      w_bsel_nxt = SEL_ALT;
      else if (w_hit_b)     w_bsel_nxt = SEL_WB;
    end
    w_fwd_sel  = (w_asel_nxt == SEL_WB) | (w_bsel_nxt == SEL_WB);
    w_bubble   = id_valid & w_kill;
  end

  // Stage registers: advance ID->EX->WB, or hold while stalled and remember a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_asel       <= SEL_REG;
      r_ex_bsel       <= SEL_REG;
      r_ex_valid      <= 1'b0;
      r_ex_rd         <= '0;
      r_ex_regwen     <= 1'b0;
      r_wb_valid      <= 1'b0;
      r_wb_rd         <= '0;
      r_wb_regwen     <= 1'b0;
      r_pending_flush <= 1'b0;
    end else if (w_adv) begin
      r_wb_valid      <= r_ex_valid;
      r_wb_rd         <= r_ex_rd;
      r_wb_regwen     <= r_ex_regwen & r_ex_valid;
      r_ex_valid      <= w_id_live;
      r_ex_rd         <= id_rd;
      r_ex_regwen     <= id_regwen & w_id_live;
      r_ex_asel       <= w_asel_nxt;
      r_ex_bsel       <= w_bsel_nxt;
      r_pending_flush <= 1'b0;
    end else if (flush) begin
      r_pending_flush <= 1'b1;
    end
  end

  assign ex_asel   = r_ex_asel;
  assign ex_bsel   = r_ex_bsel;
  assign ex_valid  = r_ex_valid;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_regwen = r_wb_regwen;

`ifdef EX_FWD_STATS_EN
  logic [31:0] r_fwd_cnt;
  logic [31:0] r_bubble_cnt;

  // Event counters; free-running wrap, frozen during stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_cnt    <= 32'd0;
      r_bubble_cnt <= 32'd0;
    end else if (w_adv) begin
      if (w_fwd_sel) r_fwd_cnt    <= r_fwd_cnt + 32'd1;
      if (w_bubble)  r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fwd_cnt    = r_fwd_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_fwd_sel ^ w_bubble;
`endif

endmodule

// File: tb/tb_ex_operand_ctrl.sv
// tb_ex_operand_ctrl: table-driven self-checking bench for ex_operand_ctrl.
module tb_ex_operand_ctrl;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_regwen, id_uses_rs1, id_uses_rs2, id_a_is_pc, id_b_is_imm;
  logic          stall, flush;
  logic [1:0]    ex_asel, ex_bsel;
  logic          ex_valid, wb_valid, wb_regwen;
  logic [AW-1:0] wb_rd;
`ifdef EX_FWD_STATS_EN
  logic [31:0]   fwd_cnt, bubble_cnt;
`endif

  ex_operand_ctrl #(.REG_AW(AW), .FWD_X0(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_regwen   (id_regwen),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_a_is_pc  (id_a_is_pc),
    .id_b_is_imm (id_b_is_imm),
    .stall       (stall),
    .flush       (flush),
    .ex_asel     (ex_asel),
    .ex_bsel     (ex_bsel),
    .ex_valid    (ex_valid),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_regwen   (wb_regwen)
`ifdef EX_FWD_STATS_EN
    ,
    .fwd_cnt     (fwd_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic [AW-1:0] rs1, rs2, rd;
    logic          regwen, u1, u2, apc, bimm, stall, flush;
    logic [1:0]    asel, bsel;
    logic          ev, wv;
    logic [AW-1:0] wrd;
    logic          wreg;
  } vec_t;

  typedef struct {
    logic [11:0] outs;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int valid, rs1, rs2, rd, regwen, u1, u2, apc, bimm,
                              stl, fl, asel, bsel, ev, wv, wrd, wreg);
    vec_t v;
    v.valid = 1'(valid);  v.rs1 = AW'(rs1);   v.rs2 = AW'(rs2);   v.rd = AW'(rd);
    v.regwen = 1'(regwen); v.u1 = 1'(u1);     v.u2 = 1'(u2);
    v.apc = 1'(apc);      v.bimm = 1'(bimm);  v.stall = 1'(stl);  v.flush = 1'(fl);
    v.asel = 2'(asel);    v.bsel = 2'(bsel);  v.ev = 1'(ev);      v.wv = 1'(wv);
    v.wrd = AW'(wrd);     v.wreg = 1'(wreg);
    return v;
  endfunction

  function automatic logic [11:0] outs_now();
    return {ex_asel, ex_bsel, ex_valid, wb_valid, wb_rd, wb_regwen};
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare against the DUT after the edge
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at time %0t", $time);
    end else begin
      e = sb.pop_front();
      check_val(e.name, 32'(outs_now()), 32'(e.outs));
    end
  endtask

  // Drive one ID cycle at the falling edge, record its expectation, sample after the rising edge
  task automatic step(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_regwen = v.regwen; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    id_a_is_pc = v.apc; id_b_is_imm = v.bimm; stall = v.stall; flush = v.flush;
    e.outs = {v.asel, v.bsel, v.ev, v.wv, v.wrd, v.wreg};
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_regwen = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_a_is_pc = 1'b0; id_b_is_imm = 1'b0; stall = 1'b0; flush = 1'b0;
    #3;
    check_val("reset_outputs", 32'(outs_now()), 32'd0);
    #20;
    rst_n = 1'b1;

    // valid rs1 rs2 rd wen u1 u2 apc imm stall flush | asel bsel ev wv wrd wreg
    tbl.push_back(mk(1, 1, 0, 5, 1, 1, 0, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0));  // addi rd5
    tbl.push_back(mk(1, 5, 6, 5, 1, 1, 1, 0, 0, 0, 0,   2, 0, 1, 1, 5, 1));  // rs1 dep
    tbl.push_back(mk(1, 5, 5, 7, 1, 1, 1, 0, 0, 0, 0,   2, 2, 1, 1, 5, 1));  // youngest wins
    tbl.push_back(mk(1, 7, 7, 0, 1, 1, 1, 1, 1, 0, 0,   1, 1, 1, 1, 7, 1));  // pc/imm win
    tbl.push_back(mk(1, 0, 0, 8, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 1));  // x0 no fwd
    tbl.push_back(mk(0, 8, 8, 8, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 8, 0));  // invalid ID
    tbl.push_back(mk(1, 8, 0, 9, 1, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 8, 0));  // bubble no fwd
    tbl.push_back(mk(1, 9, 0, 10, 1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 9, 1));  // flushed rd10
    tbl.push_back(mk(1, 10, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0)); // killed no fwd
    foreach (tbl[i]) step(tbl[i], $sformatf("row%0d", i));

    // Stall hold: forward chosen before the stall must persist
    step(mk(1, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0,   0, 1, 1, 1, 11, 1), "stall_writer");
    step(mk(1, 5, 6, 12, 1, 1, 1, 0, 0, 0, 0,  2, 0, 1, 1, 5, 1),  "stall_reader");
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 0, 20, 1, 0, 0, 1, 1, 1, 0, 2, 0, 1, 1, 5, 1), $sformatf("stall_hold%0d", i));
    step(mk(1, 12, 0, 13, 1, 1, 0, 0, 0, 0, 0, 2, 0, 1, 1, 12, 1), "stall_resume");

    // Flush arriving during a stall kills the instruction at the first advancing edge
    step(mk(1, 13, 0, 14, 1, 1, 0, 0, 0, 1, 1, 2, 0, 1, 1, 12, 1), "pflush_set");
    step(mk(1, 13, 0, 14, 1, 1, 0, 0, 0, 1, 0, 2, 0, 1, 1, 12, 1), "pflush_hold");
    step(mk(1, 13, 0, 14, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 1), "pflush_kill");
    step(mk(1, 14, 0, 15, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 14, 0), "pflush_next");

`ifdef EX_FWD_STATS_EN
    check_val("fwd_cnt", fwd_cnt, 32'd4);
    check_val("bubble_cnt", bubble_cnt, 32'd2);
`endif

    // Async reset while stalled with a pending flush
    step(mk(1, 15, 0, 16, 1, 1, 0, 0, 1, 0, 0, 2, 1, 1, 1, 15, 1), "prerst_fwd");
    step(mk(1, 1, 1, 17, 1, 1, 1, 0, 0, 1, 1,  2, 1, 1, 1, 15, 1), "prerst_stall_flush");
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_outputs", 32'(outs_now()), 32'd0);
`ifdef EX_FWD_STATS_EN
    check_val("reset_cnts", fwd_cnt | bubble_cnt, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    step(mk(1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0), "postrst_first");
    step(mk(1, 3, 3, 4, 1, 1, 1, 0, 0, 0, 0,  2, 2, 1, 1, 3, 1), "postrst_fwd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_ctrl.md
Name: ex_operand_ctrl

Overview:
- Control sequencer for the EX-stage operand mux. Encodings: asel 0=rs1, 1=pc, 2=wb_val; bsel 0=rs2, 1=imm, 2=wb_val.
- Sits between decode (ID) and EX of the 3-stage pipeline (ID, EX, WB).
- Tracks destination-register state of the EX and WB stages in its own pipeline registers.
- Drives registered asel/bsel so that EX sees each select at the same edge its instruction enters EX.
- Handles stall, flush and x0 rules.

Parameters:
- REG_AW, 5, register index width.
- FWD_X0, 0, if 1 a write to x0 may still forward (debug only; normal = 0).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_AW  source 1 index.
- id_rs2  input  REG_AW  source 2 index.
- id_rd  input  REG_AW  destination index.
- id_regwen  input  1  instruction writes rd.
- id_uses_rs1  input  1  operand A reads rs1.
- id_uses_rs2  input  1  operand B reads rs2.
- id_a_is_pc  input  1  operand A is pc.
- id_b_is_imm  input  1  operand B is imm.
- stall  input  1  hold ID/EX/WB (memory or IO not ready).
- flush  input  1  kill the instruction in ID (branch/jump redirect resolved in EX).
- ex_asel  output  2  operand A select for EX.
- ex_bsel  output  2  operand B select for EX.
- ex_valid  output  1  EX holds a real instruction.
- wb_valid  output  1  WB holds a real instruction.
- wb_rd  output  REG_AW  WB destination index.
- wb_regwen  output  1  WB writes the regfile (already gated by wb_valid).

Behaviour:
- Reset (async, rst_n low): ex_asel=0, ex_bsel=0, ex_valid=0, wb_valid=0, wb_rd=0, wb_regwen=0.
  - Internal EX rd/regwen and pending_flush are also cleared.
  - Reset mid-stall or mid-flush discards all state.
- Advance = !stall.
- On an advancing edge:
  - WB <= EX: wb_valid<=ex_valid; wb_rd<=ex_rd; wb_regwen<=ex_regwen & ex_valid.
  - EX <= ID: ex_valid<=id_valid & !kill, where kill = flush | pending_flush. ex_rd<=id_rd; ex_regwen<=id_regwen.
- Forward condition, evaluated against the current EX stage (which becomes WB at the same edge):
  - hitA = id_uses_rs1 & ex_valid & ex_regwen & (ex_rd==id_rs1) & (id_rs1!=0 | FWD_X0).
  - hitB is the same with rs2.
- Select priority, per operand:
  - ex_asel <= id_a_is_pc ? 1 : hitA ? 2 : 0.
  - ex_bsel <= id_b_is_imm ? 1 : hitB ? 2 : 0.
  - pc/imm always win over forwarding.
- Killed or invalid ID instruction: ex_valid<=0, ex_asel<=0, ex_bsel<=0, ex_regwen<=0. A bubble never forwards.
- Stalled edge: every output and internal register holds.
  - wb_val upstream stays stable, so a forward selected before the stall stays correct.
- Flush during stall:
  - pending_flush<=1 on any stalled edge with flush=1.
  - Consumed and cleared on the first advancing edge.
  - flush and stall both high: no state change except pending_flush<=1.
- Back-to-back writers to the same rd: the youngest (EX) always wins. Only the EX->WB distance exists; older values come from the regfile.
- Latency: one edge from ID inputs to ex_* outputs, and one further edge to wb_*.
- No combinational path from any input to any output.

Optional Feature:
- Macro EX_FWD_STATS_EN.
- When defined, add outputs:
  - fwd_cnt[31:0]: increments once per advancing edge where hitA or hitB is selected (at most +1 per edge).
  - bubble_cnt[31:0]: increments per advancing edge where id_valid=1 and the ID instruction is killed.
  - Both counters wrap at 2^32, reset to 0, and hold during stall.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-traffic with stall=1 -> all outputs 0 immediately (async); pending_flush cleared, so the first ID instruction after release is not killed.
- Back-to-back dependency: cycle n ID addi rd=5; cycle n+1 ID add rs1=5, rs2=6 -> after the n+1 edge, ex_asel=2, ex_bsel=0; with rs2=5 as well, ex_bsel=2.
- Priority and x0: writer rd=0, then reader rs1=0 -> ex_asel=0. Writer rd=7, then reader with id_a_is_pc=1, rs1=7 -> ex_asel=1. With id_b_is_imm=1 -> ex_bsel=1.
- Stall hold: dependency as above, then stall=1 for 3 cycles -> ex_asel stays 2, wb_rd=5 held, ex_valid unchanged; advance resumes normally.
- Flush during stall: stall=1 and flush=1 for one cycle, then flush=0, then stall=0 -> the ID instruction at the first advancing edge gets ex_valid=0, ex_asel=0; the next instruction is valid.
- Bubble no-forward: killed writer rd=9, then reader rs1=9 -> ex_asel=0 and wb_regwen=0. With EX_FWD_STATS_EN: bubble_cnt=1, fwd_cnt=0.
